// File: rtl/rfphoenix_dcache_rway.sv
// Read-side tag store and way lookup for the 4-way data cache.
// Holds per-set tags and valid bits for all ways. A lookup returns hit/rway on the next cycle.
// Line fills write tags, and a line or the whole cache can be invalidated.
// Also supplies the LFSR bits used to pick the replacement way on fills.
module rfphoenix_dcache_rway #(
    parameter int unsigned LINES = 64,
    parameter int unsigned LOBIT = 6,
    parameter int unsigned AWID  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rd_i,
    input  logic [AWID-1:0] adr_i,
    input  logic            wr_dc,
    input  logic [1:0]      wway,
    input  logic [AWID-1:0] wadr,
    input  logic            inv_line,
    input  logic [AWID-1:0] inv_adr,
    input  logic            inv_all,
    output logic            hit,
    output logic [1:0]      rway,
    output logic [1:0]      lfsr,
    output logic            busy
);

    localparam int unsigned IW = $clog2(LINES);
    localparam int unsigned TW = AWID - LOBIT - IW;

    typedef enum logic {StIdle, StWalk} state_e;

    state_e          st_q;
    logic [IW-1:0]   idx_q;
    logic            busy_q;
    logic            hit_q;
    logic [1:0]      rway_q;
    logic [7:0]      lfsr_q;

    logic [TW-1:0]    tag_q [4][LINES];
    logic [LINES-1:0] vld_q [4];

    logic [IW-1:0] rd_idx, wr_idx, inv_idx, walk_idx;
    logic [TW-1:0] rd_tag, wr_tag, inv_tag;
    logic [3:0]    match;
    logic [1:0]    lk_way;
    logic [7:0]    lfsr_d;
    logic          unused_adr;

    assign rd_idx  = adr_i[LOBIT+IW-1:LOBIT];
    assign rd_tag  = adr_i[AWID-1:LOBIT+IW];
    assign wr_idx  = wadr[LOBIT+IW-1:LOBIT];
    assign wr_tag  = wadr[AWID-1:LOBIT+IW];
    assign inv_idx = inv_adr[LOBIT+IW-1:LOBIT];
    assign inv_tag = inv_adr[AWID-1:LOBIT+IW];

    assign unused_adr = ^{adr_i[LOBIT-1:0], wadr[LOBIT-1:0], inv_adr[LOBIT-1:0]};

    // A restart during the walk clears index 0 in the same cycle it is requested.
    assign walk_idx = inv_all ? '0 : idx_q;

    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    // Compare lookup tag against all ways; a same-set fill is forwarded into its way.
    always_comb begin
        match = '0;
        for (int w = 0; w < 4; w++) begin
            if (wr_dc && (wway == 2'(w)) && (wr_idx == rd_idx)) begin
                match[w] = (wr_tag == rd_tag);
            end else begin
                match[w] = vld_q[w][rd_idx] && (tag_q[w][rd_idx] == rd_tag);
            end
        end
    end

    // Lowest-numbered matching way wins.
    always_comb begin
        lk_way = 2'd0;
        for (int w = 3; w >= 0; w--) begin
            if (match[w]) begin
                lk_way = 2'(w);
            end
        end
    end

    // Tag/valid storage: walk clears, else invalidate then fill (fill wins on overlap).
    always_ff @(posedge clk) begin
        for (int w = 0; w < 4; w++) begin
            if (st_q == StWalk) begin
                vld_q[w][walk_idx] <= 1'b0;
            end else begin
                if (inv_line && (tag_q[w][inv_idx] == inv_tag)) begin
                    vld_q[w][inv_idx] <= 1'b0;
                end
                if (wr_dc && (wway == 2'(w))) begin
                    vld_q[w][wr_idx] <= 1'b1;
                    tag_q[w][wr_idx] <= wr_tag;
                end
            end
        end
    end

    // Control FSM with registered lookup result, busy flag and LFSR.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= StWalk;
            idx_q  <= '0;
            busy_q <= 1'b1;
            hit_q  <= 1'b0;
            rway_q <= 2'd0;
            lfsr_q <= 8'h01;
        end else begin
            lfsr_q <= lfsr_d;
            hit_q  <= 1'b0;
            case (st_q)
                StIdle: begin
                    if (rd_i) begin
                        hit_q  <= |match;
                        rway_q <= lk_way;
                    end
                    if (inv_all) begin
                        st_q   <= StWalk;
                        idx_q  <= '0;
                        busy_q <= 1'b1;
                    end
                end
                StWalk: begin
                    idx_q <= walk_idx + IW'(1);
                    if (walk_idx == IW'(LINES - 1)) begin
                        st_q   <= StIdle;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    st_q <= StIdle;
                end
            endcase
        end
    end

    assign hit  = hit_q;
    assign rway = rway_q;
    assign lfsr = lfsr_q[1:0];
    assign busy = busy_q;

endmodule

// File: tb/tb_rfphoenix_dcache_rway.sv
// Scoreboard bench for the data cache read-way tag store.
// The driver updates a set/way reference model each cycle and queues the expected outputs.
// The monitor compares those against the DUT just after each clock edge.
module tb_rfphoenix_dcache_rway;

    localparam int LINES = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_i = 1'b0;
    logic [31:0] adr_i = '0;
    logic        wr_dc = 1'b0;
    logic [1:0]  wway = '0;
    logic [31:0] wadr = '0;
    logic        inv_line = 1'b0;
    logic [31:0] inv_adr = '0;
    logic        inv_all = 1'b0;
    logic        hit;
    logic [1:0]  rway;
    logic [1:0]  lfsr;
    logic        busy;

    rfphoenix_dcache_rway dut (
        .clk      (clk),
        .rst      (rst),
        .rd_i     (rd_i),
        .adr_i    (adr_i),
        .wr_dc    (wr_dc),
        .wway     (wway),
        .wadr     (wadr),
        .inv_line (inv_line),
        .inv_adr  (inv_adr),
        .inv_all  (inv_all),
        .hit      (hit),
        .rway     (rway),
        .lfsr     (lfsr),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       hit;
        bit [1:0] rway;
        bit       chk_rway;
        bit       busy;
        bit [1:0] lfsr;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model: cache contents per way/set, remaining walk cycles, LFSR.
    bit        m_valid [4][LINES];
    bit [19:0] m_tag   [4][LINES];
    int        m_rem;
    bit [7:0]  m_lfsr;
    bit [1:0]  m_rway;
    bit        busy_s;

    function automatic int set_of(input bit [31:0] a);
        return int'(a[11:6]);
    endfunction

    function automatic bit [19:0] tag_of(input bit [31:0] a);
        return a[31:12];
    endfunction

    task automatic clear_model();
        for (int w = 0; w < 4; w++)
            for (int s = 0; s < LINES; s++)
                m_valid[w][s] = 1'b0;
    endtask

    task automatic drive(input bit r, input bit rd, input bit [31:0] a,
                         input bit wr, input bit [1:0] ww, input bit [31:0] wa,
                         input bit il, input bit [31:0] iadr, input bit iall);
        exp_t e;
        bit   v;
        bit [19:0] t;
        @(negedge clk);
        busy_s   = busy;
        rst      = r;
        rd_i     = rd;
        adr_i    = a;
        wr_dc    = wr;
        wway     = ww;
        wadr     = wa;
        inv_line = il;
        inv_adr  = iadr;
        inv_all  = iall;
        e.hit = 1'b0;
        e.chk_rway = 1'b0;
        if (r) begin
            m_rem  = LINES;
            m_lfsr = 8'h01;
            m_rway = 2'd0;
            e.chk_rway = 1'b1;
            clear_model();
        end else begin
            m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
            if (m_rem > 0) begin
                m_rem = iall ? LINES - 1 : m_rem - 1;
            end else begin
                if (rd) begin
                    for (int w = 0; w < 4 && !e.hit; w++) begin
                        v = m_valid[w][set_of(a)];
                        t = m_tag[w][set_of(a)];
                        if (wr && ww == 2'(w) && set_of(wa) == set_of(a)) begin
                            v = 1'b1;
                            t = tag_of(wa);
                        end
                        if (v && t == tag_of(a)) begin
                            e.hit  = 1'b1;
                            m_rway = 2'(w);
                        end
                    end
                    e.chk_rway = e.hit;
                end
                if (il)
                    for (int w = 0; w < 4; w++)
                        if (m_valid[w][set_of(iadr)] && m_tag[w][set_of(iadr)] == tag_of(iadr))
                            m_valid[w][set_of(iadr)] = 1'b0;
                if (wr) begin
                    m_valid[ww][set_of(wa)] = 1'b1;
                    m_tag[ww][set_of(wa)]   = tag_of(wa);
                end
                if (iall) begin
                    m_rem = LINES;
                    clear_model();
                end
            end
        end
        e.rway = m_rway;
        e.busy = (m_rem > 0);
        e.lfsr = m_lfsr[1:0];
        exp_q.push_back(e);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic look(input bit [31:0] a);
        drive(0, 1, a, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic fill(input bit [1:0] ww, input bit [31:0] wa);
        drive(0, 0, 0, 1, ww, wa, 0, 0, 0);
    endtask

    task automatic check_count(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    function automatic bit [31:0] rnd_adr();
        bit [31:0] a;
        a[31:12] = 20'(($urandom_range(0, 3) * 20'h1357) + 20'h1);
        a[11:6]  = 6'($urandom_range(0, 3));
        a[5:0]   = 6'($urandom);
        return a;
    endfunction

    // Monitor: compare every cycle's outputs against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (hit !== e.hit) begin
                    errors++;
                    $display("FAIL hit @%0t: got %b want %b", $time, hit, e.hit);
                end
                checks++;
                if (busy !== e.busy) begin
                    errors++;
                    $display("FAIL busy @%0t: got %b want %b", $time, busy, e.busy);
                end
                checks++;
                if (lfsr !== e.lfsr) begin
                    errors++;
                    $display("FAIL lfsr @%0t: got %0d want %0d", $time, lfsr, e.lfsr);
                end
                if (e.chk_rway) begin
                    checks++;
                    if (rway !== e.rway) begin
                        errors++;
                        $display("FAIL rway @%0t: got %0d want %0d", $time, rway, e.rway);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        bit [31:0] a;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset release: busy walk length.
        idle();
        n = busy_s ? 1 : 0;
        for (int i = 0; i < 200; i++) begin
            idle();
            if (busy_s) n++;
            else break;
        end
        check_count("reset_busy_len", n, 64);
        look(32'h0000_1000);
        idle();

        // Fill then lookup another offset in the same line.
        fill(2, 32'h0001_2340);
        look(32'h0001_2378);
        idle();

        // Same-cycle fill and lookup forwarded.
        drive(0, 1, 32'h0000_8040, 1, 1, 32'h0000_8040, 0, 0, 0);
        idle();

        // Duplicate tag in ways 0 and 3, then invalidate the line.
        fill(0, 32'h0003_4480);
        fill(3, 32'h0003_4480);
        look(32'h0003_4480);
        drive(0, 1, 32'h0003_4480, 0, 0, 0, 1, 32'h0003_4480, 0);
        look(32'h0003_4480);
        idle();

        // Fill and invalidate the same set/way in one cycle: fill wins.
        drive(0, 0, 0, 1, 2, 32'h0005_0100, 1, 32'h0005_0100, 0);
        look(32'h0005_0100);
        idle();

        // Invalidate-all with a restart part way through the walk.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            drive(0, 1, 32'h0001_2340, 1, 0, 32'h0001_2340, 0, 0, i == 20);
            if (busy_s) n++;
            else break;
        end
        check_count("inv_all_restart_len", n, 84);
        look(32'h0001_2340);
        look(32'h0000_8040);
        look(32'h0005_0100);

        // Randomized traffic over a small tag/set space to provoke hits and conflicts.
        for (int i = 0; i < 3000; i++) begin
            a = rnd_adr();
            drive(0, $urandom_range(0, 1) == 1, a,
                  $urandom_range(0, 9) < 3, 2'($urandom), rnd_adr(),
                  $urandom_range(0, 9) == 0, ($urandom_range(0, 1) == 1) ? a : rnd_adr(),
                  $urandom_range(0, 399) == 0);
        end

        idle();
        idle();
        @(posedge clk);
        #2;
        check_count("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
